subterranean_sae_ctrl: RTL
==========================

// Module: subterranean_sae_ctrl
// PURPOSE
//  Sequencer for the 4-round-per-cycle Subterranean duplex datapath. Runs full SAE flow:
//  init, absorb key, absorb nonce, blank(8), absorb AD, encrypt/decrypt message, blank(8), squeeze 128-bit tag.
//  Drives datapath init/start/encrypt/decrypt/enable_round/din/din_size; buffers one output block.
//  Sits between the host stream interface and the round datapath.
// PARAMETERS
//  none (block width fixed at 128 bits / 16 bytes, 4 duplex calls per cycle max)
// PORTS
//  clk            in   1    clock
//  arstn          in   1    asynchronous active-low reset
//  cmd_valid      in   1    start SAE operation
//  cmd_ready      out  1    high only in IDLE
//  cmd_decrypt    in   1    0=encrypt, 1=decrypt; sampled at cmd accept
//  key            in   128  sampled at cmd accept
//  nonce          in   128  sampled at cmd accept
//  in_valid       in   1    AD/message block valid (AD blocks first, then message)
//  in_ready       out  1    block consumed this cycle
//  in_data        in   128  byte i in bits [8i+7:8i]
//  in_size        in   5    byte count 0..16 (only honoured with in_last; else treated as 16)
//  in_last        in   1    last block of current phase (AD or message)
//  out_valid      out  1    output block valid
//  out_ready      in   1    consumer accepts
//  out_data       out  128  ciphertext/plaintext or tag
//  out_size       out  5    valid bytes; 16 for tag
//  out_tag        out  1    out_data is the tag
//  busy           out  1    not IDLE
//  dp_init        out  1    clear datapath state
//  dp_start       out  1    datapath advances this cycle
//  dp_encrypt     out  1    datapath encrypt
//  dp_decrypt     out  1    datapath decrypt
//  dp_enable_round out 2    rounds-1 applied this cycle
//  dp_din         out  128  datapath input
//  dp_din_size    out  12   3 bits per 32-bit lane: lane i in [3i+2:3i], value 0..4 bytes
//  dp_dout        in   128  datapath output, combinational from dp_din and state
// BEHAVIOUR
//  Reset (async): state IDLE; out_valid=0; out_data=0; out_size=0; out_tag=0; key/nonce/op regs cleared. All dp_* outputs 0 outside active cycles.
//  FSM: IDLE > KEY > KPAD > NONCE > NPAD > BLK0 > BLK1 > AD [> ADPAD] > MSG [> MPAD] > BLK2 > BLK3 > TAG > IDLE.
//  IDLE: cmd_valid&cmd_ready > dp_init=1, latch key/nonce/op, next KEY.
//  Lane size: lane_i = min(max(N-4i,0),4).
//  KEY/NONCE: dp_start=1, din=key/nonce, din_size=12'h924, enable_round=3.
//  KPAD/NPAD/xPAD: dp_start=1, din=0, din_size=0, enable_round=0, enc=dec=0.
//  BLKn: dp_start=1, din=0, din_size=0, enable_round=3. Each of these states lasts one cycle.
//  AD: in_ready=in_valid. On consume: dp_start=1, din=in_data, enc=dec=0.
//  AD non-last: enable_round=3, din_size=12'h924.
//  AD last, N<16: enable_round=N>>2, din_size per lane rule.
//  AD last, N=16: enable_round=3, then ADPAD.
//  AD last next state: MSG (via ADPAD when N=16).
//  MSG: same sizing as AD; dp_encrypt=!op, dp_decrypt=op.
//  MSG consumes only when in_valid & (!out_valid | out_ready). Same cycle: out_data<=dp_dout, out_size<=N (16 if non-last), out_tag<=0, out_valid<=1.
//  MSG last next state: BLK2 (via MPAD when N=16).
//  TAG: waits for (!out_valid | out_ready). Then dp_start=1, din=0, din_size=0, enable_round=3; out_data<=dp_dout, out_size<=16, out_tag<=1; next IDLE.
//  Output register: out_valid clears on out_ready unless reloaded same cycle (simultaneous drain+load keeps out_valid=1).
//  Empty AD/message: host sends one last block with in_size=0, giving one empty duplex (enable_round=0).
//  dp_start=0 whenever stalled; datapath state then holds.
//  Latency: cmd accept to first AD consume = 7 cycles minimum.
//  Tag comparison for decrypt is done by the host.
//  Reset mid-operation aborts immediately to IDLE. The next command re-inits via dp_init.
// TESTING
//  Reset: arstn=0 mid-MSG -> next cycle IDLE, out_valid=0, cmd_ready=1, dp_start=0.
//  Encrypt, empty AD + empty msg (size 0, last): dp sequence init, key(924,3), pad(0,0), nonce, pad, blank x2, AD(0,0), MSG(0,0), blank x2, TAG. Outputs: one out block size 0, then tag matching golden model.
//  MSG last N=5: dp_enable_round=1, dp_din_size=12'h00C, out_size=5, out_data bytes 5..15 equal in_data.
//  AD last N=16: two dp cycles, (924,3) then (000,0); MSG starts the following cycle.
//  Backpressure: out_ready=0, two MSG blocks -> second in_ready=0 and dp_start=0 until first drains. Tag deferred likewise.
//  Round trip: decrypt of encrypt output (AD 20B, msg 33B) returns plaintext; identical tag.

Source files
------------

// File: rtl/subterranean_sae_ctrl.sv
// SAE sequencer for the 4-round Subterranean duplex datapath: walks key/nonce/AD/message/tag
// phases, sizes each duplex call per 32-bit lane and buffers one output block.

module subterranean_sae_lane #(
  parameter int LANE = 0
) (
  input  logic [4:0] n,
  output logic [2:0] sz
);
  localparam logic [4:0] LO = 5'(4 * LANE);

  always_comb begin
    if (n >= LO + 5'd4) sz = 3'd4;
    else if (n > LO)    sz = 3'(n - LO);
    else                sz = 3'd0;
  end
endmodule

module subterranean_sae_ctrl (
  input  logic         clk,
  input  logic         arstn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_decrypt,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [4:0]   in_size,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [4:0]   out_size,
  output logic         out_tag,
  output logic         busy,
  output logic         dp_init,
  output logic         dp_start,
  output logic         dp_encrypt,
  output logic         dp_decrypt,
  output logic [1:0]   dp_enable_round,
  output logic [127:0] dp_din,
  output logic [11:0]  dp_din_size,
  input  logic [127:0] dp_dout
);
  localparam int NUM_LANES = 4;

  typedef enum logic [3:0] {
    IDLE, KEY, KPAD, NONCE, NPAD, BLK0, BLK1, AD, ADPAD, MSG, MPAD, BLK2, BLK3, TAG
  } state_t;

  typedef struct packed {
    logic         init;
    logic         start;
    logic         enc;
    logic         dec;
    logic [1:0]   er;
    logic [127:0] din;
    logic [11:0]  din_size;
  } dp_req_t;

  state_t  state, state_nx;
  dp_req_t dp;
  logic [127:0] key_q, nonce_q;
  logic         op_q;
  logic [NUM_LANES-1:0][2:0] lane_sz;
  logic         n_full, out_free, load_msg, load_tag;
  logic [4:0]   blk_n;
  logic [1:0]   blk_er;

  // Non-last blocks are always full regardless of in_size.
  assign n_full   = !in_last || (in_size >= 5'd16);
  assign blk_n    = n_full ? 5'd16 : in_size;
  assign blk_er   = n_full ? 2'd3 : blk_n[3:2];
  assign out_free = !out_valid || out_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    subterranean_sae_lane #(.LANE(i)) u_lane (.n(blk_n), .sz(lane_sz[i]));
  end

  always_comb begin
    state_nx = state;
    dp       = '0;
    in_ready = 1'b0;
    load_msg = 1'b0;
    load_tag = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        dp.init  = 1'b1;
        state_nx = KEY;
      end
      KEY: begin
        dp.start = 1'b1; dp.din = key_q; dp.din_size = 12'h924; dp.er = 2'd3;
        state_nx = KPAD;
      end
      KPAD: begin dp.start = 1'b1; state_nx = NONCE; end
      NONCE: begin
        dp.start = 1'b1; dp.din = nonce_q; dp.din_size = 12'h924; dp.er = 2'd3;
        state_nx = NPAD;
      end
      NPAD:  begin dp.start = 1'b1; state_nx = BLK0; end
      BLK0:  begin dp.start = 1'b1; dp.er = 2'd3; state_nx = BLK1; end
      BLK1:  begin dp.start = 1'b1; dp.er = 2'd3; state_nx = AD; end
      AD: if (in_valid) begin
        in_ready = 1'b1;
        dp.start = 1'b1; dp.din = in_data; dp.din_size = lane_sz; dp.er = blk_er;
        if (in_last) state_nx = n_full ? ADPAD : MSG;
      end
      ADPAD: begin dp.start = 1'b1; state_nx = MSG; end
      // Only consume when the output buffer can take the result.
      MSG: if (in_valid && out_free) begin
        in_ready = 1'b1;
        dp.start = 1'b1; dp.din = in_data; dp.din_size = lane_sz; dp.er = blk_er;
        dp.enc   = !op_q; dp.dec = op_q;
        load_msg = 1'b1;
        if (in_last) state_nx = n_full ? MPAD : BLK2;
      end
      MPAD:  begin dp.start = 1'b1; state_nx = BLK2; end
      BLK2:  begin dp.start = 1'b1; dp.er = 2'd3; state_nx = BLK3; end
      BLK3:  begin dp.start = 1'b1; dp.er = 2'd3; state_nx = TAG; end
      TAG: if (out_free) begin
        dp.start = 1'b1; dp.er = 2'd3;
        load_tag = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_ready       = (state == IDLE);
  assign busy            = (state != IDLE);
  assign dp_init         = dp.init;
  assign dp_start        = dp.start;
  assign dp_encrypt      = dp.enc;
  assign dp_decrypt      = dp.dec;
  assign dp_enable_round = dp.er;
  assign dp_din          = dp.din;
  assign dp_din_size     = dp.din_size;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      key_q   <= '0;
      nonce_q <= '0;
      op_q    <= 1'b0;
    end else if (state == IDLE && cmd_valid) begin
      key_q   <= key;
      nonce_q <= nonce;
      op_q    <= cmd_decrypt;
    end
  end

  // A load in the same cycle as a drain keeps out_valid high.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_size  <= '0;
      out_tag   <= 1'b0;
    end else if (load_msg) begin
      out_valid <= 1'b1;
      out_data  <= dp_dout;
      out_size  <= blk_n;
      out_tag   <= 1'b0;
    end else if (load_tag) begin
      out_valid <= 1'b1;
      out_data  <= dp_dout;
      out_size  <= 5'd16;
      out_tag   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
